counter_sequencer: RTL and testbench

- Controller that sequences a 4-bit up-counter datapath: start, pause, resume, clear and load of a terminal value through a valid/ready command port.
- Adds a programmable prescaler and one-shot or periodic operation, and emits a one-cycle terminal-count pulse.
- Sits between the register/host logic and any consumer of a timed count or event tick.

---
 rtl/counter_sequencer.sv | 171 +++++++++++++++++
 tb/tb_counter_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
//
// Purpose:
//   Sequences a WIDTH-bit up-counter through a valid/ready command port.
//   Commands clear the count, load a terminal (limit) value, start/resume
//   and stop (pause) counting. A programmable prescaler slows the counter
//   to one step every (prescale+1) clocks, and the counter either stops at
//   the limit (one-shot) or wraps back to zero (periodic). Each terminal
//   step produces a one-cycle tc_pulse.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset      in   asynchronous, active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted this cycle
//   cmd_op     in   00 CLEAR, 01 LOAD, 10 START, 11 STOP
//   cmd_data   in   limit value for LOAD
//   periodic   in   1 = auto-restart, 0 = one-shot (sampled on START)
//   prescale   in   step divider (sampled on START)
//   count      out  current counter value
//   tc_pulse   out  one-cycle pulse after a terminal step
//   busy       out  high while in RUN
//   done       out  high while in DONE
//   state      out  IDLE=00, RUN=01, PAUSE=10, DONE=11
// ---------------------------------------------------------------------------
module counter_sequencer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    input  logic                  periodic,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc_pulse,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    logic [1:0]            state_q,      state_d;
    logic [WIDTH-1:0]      count_q,      count_d;
    logic [WIDTH-1:0]      limit_q,      limit_d;
    logic [PRESCALE_W-1:0] presc_q,      presc_d;
    logic [PRESCALE_W-1:0] prescale_q,   prescale_d;
    logic                  periodic_q,   periodic_d;
    logic                  tc_q,         tc_d;
    logic                  ready_q,      ready_d;

    logic accept;
    logic step;

    assign accept = cmd_valid && ready_q;

    // The prescaler wraps on reaching the latched divider; that wrap is the
    // moment the counter is allowed to move.
    assign step = (state_q == RUN) && (presc_q == prescale_q);

    // Next-state logic. An accepted command always takes priority: in a
    // command cycle the prescaler and counter do not advance at all, so a
    // coincident step is simply lost rather than merged with the command.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        limit_d    = limit_q;
        presc_d    = presc_q;
        prescale_d = prescale_q;
        periodic_d = periodic_q;
        tc_d       = 1'b0;
        ready_d    = !accept;

        if (accept) begin
            case (cmd_op)
                OP_CLEAR: begin
                    count_d = '0;
                    presc_d = '0;
                    if (state_q == DONE) begin
                        state_d = IDLE;
                    end
                end
                OP_LOAD: begin
                    limit_d = cmd_data;
                end
                OP_START: begin
                    // START while already running is ignored entirely,
                    // so mode and divider are not re-sampled mid-run.
                    if (state_q != RUN) begin
                        state_d    = RUN;
                        periodic_d = periodic;
                        prescale_d = prescale;
                        if (state_q == DONE) begin
                            count_d = '0;
                            presc_d = '0;
                        end
                    end
                end
                OP_STOP: begin
                    if (state_q == RUN) begin
                        state_d = PAUSE;
                    end
                end
                default: ;
            endcase
        end else if (state_q == RUN) begin
            if (step) begin
                presc_d = '0;
                // Only exact equality terminates; a limit lowered below
                // the current count lets the counter wrap round first.
                if (count_q == limit_q) begin
                    tc_d = 1'b1;
                    if (periodic_q) begin
                        count_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                presc_d = presc_q + PRESCALE_W'(1);
            end
        end
    end

    // State registers. Reset forces the power-up values immediately,
    // including killing a tc_pulse that is currently being driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            limit_q    <= '1;
            presc_q    <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
            tc_q       <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            limit_q    <= limit_d;
            presc_q    <= presc_d;
            prescale_q <= prescale_d;
            periodic_q <= periodic_d;
            tc_q       <= tc_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign count     = count_q;
    assign tc_pulse  = tc_q;
    assign state     = state_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_counter_sequencer
//
// Purpose:
//   Self-checking bench for counter_sequencer. The stimulus process issues
//   directed commands and pushes hand-computed expected outputs, tagged
//   with the clock cycle they apply to, into a queue. An independent
//   monitor pops entries when their cycle arrives (or when reset is
//   asserted asynchronously) and compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_counter_sequencer;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    logic       clk;
    logic       reset;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdOp;
    logic [3:0] cmdData;
    logic       periodicIn;
    logic [3:0] prescaleIn;
    logic [3:0] countOut;
    logic       tcPulse;
    logic       busyOut;
    logic       doneOut;
    logic [1:0] stateOut;

    int cycle  = 0;
    int checks = 0;
    int errors = 0;

    // Expected snapshot; -1 in a field means "not checked".
    typedef struct {
        int    cyc;
        string name;
        int    cnt;
        int    st;
        int    tc;
        int    rdy;
    } exp_t;

    exp_t expQ[$];

    counter_sequencer #(
        .WIDTH      (4),
        .PRESCALE_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_op    (cmdOp),
        .cmd_data  (cmdData),
        .periodic  (periodicIn),
        .prescale  (prescaleIn),
        .count     (countOut),
        .tc_pulse  (tcPulse),
        .busy      (busyOut),
        .done      (doneOut),
        .state     (stateOut)
    );

    // 100 MHz-style clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle number = rising edges seen so far; expectations are keyed on it.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input string field,
                               input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d (cycle %0d)",
                     name, field, actual, required, cycle);
        end
    endtask

    task automatic compareEntry(input exp_t e);
        if (e.cnt >= 0) checkOutput(e.name, "count", int'(countOut), e.cnt);
        if (e.st >= 0) begin
            checkOutput(e.name, "state", int'(stateOut), e.st);
            checkOutput(e.name, "busy", int'(busyOut), (e.st == 1) ? 1 : 0);
            checkOutput(e.name, "done", int'(doneOut), (e.st == 3) ? 1 : 0);
        end
        if (e.tc >= 0)  checkOutput(e.name, "tc_pulse", int'(tcPulse), e.tc);
        if (e.rdy >= 0) checkOutput(e.name, "cmd_ready", int'(cmdReady), e.rdy);
    endtask

    // Monitor: on every falling edge (and shortly after an asynchronous
    // reset assertion) compare all expectations that are now due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge reset);
            if (reset) #1;
            while (expQ.size() > 0 && expQ[0].cyc <= cycle) begin
                e = expQ.pop_front();
                compareEntry(e);
            end
        end
    end

    // Queue an expectation for (current cycle + offset).
    task automatic expectAt(input int offset, input string name, input int cnt,
                            input int st, input int tc, input int rdy);
        exp_t e;
        e.cyc  = cycle + offset;
        e.name = name;
        e.cnt  = cnt;
        e.st   = st;
        e.tc   = tc;
        e.rdy  = rdy;
        expQ.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command and hold it until it is accepted; returns one
    // time unit after the accepting edge, so 'cycle' is the accept cycle.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] data,
                                 input logic per, input logic [3:0] pre);
        bit got;
        got        = 1'b0;
        cmdOp      = op;
        cmdData    = data;
        periodicIn = per;
        prescaleIn = pre;
        cmdValid   = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            got = cmdReady;
            @(posedge clk);
            #1;
        end
        cmdValid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL handshake: got cmd_ready=0 for 8 cycles, expected acceptance");
        end
    endtask

    task automatic printSummary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    // Safety net so the run always terminates.
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
        printSummary();
        $finish;
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        reset      = 1'b1;
        cmdValid   = 1'b0;
        cmdOp      = OP_CLEAR;
        cmdData    = 4'd0;
        periodicIn = 1'b0;
        prescaleIn = 4'd0;
        tick(3);
        reset = 1'b0;
        expectAt(0, "rstVal", 0, IDLE, 0, 1);

        // Count to 7 with default limit, then reset asynchronously mid-run.
        applyStimulus(OP_START, 4'd0, 1'b0, 4'd0);
        expectAt(0, "start0", 0, RUN, 0, 0);
        expectAt(7, "run7", 7, RUN, 0, 1);
        tick(7);
        #5;
        expectAt(0, "asyncRst", 0, IDLE, 0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expectAt(0, "postRst", 0, IDLE, 0, 1);

        // Limit back at 15 after reset: 15 is terminal, not a wrap.
        applyStimulus(OP_START, 4'd0, 1'b0, 4'd0);
        expectAt(15, "cnt15", 15, RUN, 0, 1);
        expectAt(16, "term15", 15, DONE, 1, 1);
        expectAt(17, "hold15", 15, DONE, 0, 1);
        tick(17);
        applyStimulus(OP_CLEAR, 4'd0, 1'b0, 4'd0);
        expectAt(0, "clrDone", 0, IDLE, 0, 0);
        expectAt(1, "rdyBack", 0, IDLE, 0, 1);

        // One-shot to limit 5, then restart from DONE.
        applyStimulus(OP_LOAD, 4'd5, 1'b0, 4'd0);
        applyStimulus(OP_START, 4'd0, 1'b0, 4'd0);
        expectAt(0, "os0", 0, RUN, 0, 0);
        for (int k = 1; k <= 5; k++) expectAt(k, "osCnt", k, RUN, 0, -1);
        expectAt(6, "osTerm", 5, DONE, 1, -1);
        expectAt(7, "osHold", 5, DONE, 0, -1);
        tick(7);
        applyStimulus(OP_START, 4'd0, 1'b0, 4'd0);
        expectAt(0, "restart", 0, RUN, 0, 0);
        expectAt(1, "restart1", 1, RUN, 0, 1);
        applyStimulus(OP_STOP, 4'd0, 1'b0, 4'd0);
        expectAt(0, "stopHold", 1, PAUSE, 0, 0);
        applyStimulus(OP_CLEAR, 4'd0, 1'b0, 4'd0);
        expectAt(0, "clrPause", 0, PAUSE, 0, 0);

        // Periodic, limit 3, prescale 2: one step every 3 clocks.
        applyStimulus(OP_LOAD, 4'd3, 1'b0, 4'd0);
        applyStimulus(OP_START, 4'd0, 1'b1, 4'd2);
        expectAt(0, "per0", 0, RUN, 0, 0);
        for (int k = 1; k <= 25; k++)
            expectAt(k, "perCnt", (k / 3) % 4, RUN, (k % 12 == 0) ? 1 : 0, -1);
        tick(25);
        applyStimulus(OP_STOP, 4'd0, 1'b0, 4'd0);
        expectAt(0, "perStop", 0, PAUSE, 0, 0);
        applyStimulus(OP_CLEAR, 4'd0, 1'b0, 4'd0);

        // Pause at 2 with limit 9, hold, then resume with prescale 1.
        applyStimulus(OP_LOAD, 4'd9, 1'b0, 4'd0);
        applyStimulus(OP_START, 4'd0, 1'b0, 4'd0);
        tick(2);
        applyStimulus(OP_STOP, 4'd0, 1'b0, 4'd0);
        for (int k = 0; k < 10; k++) expectAt(k, "pauseHold", 2, PAUSE, 0, -1);
        tick(10);
        applyStimulus(OP_START, 4'd0, 1'b0, 4'd1);
        expectAt(0, "resume0", 2, RUN, 0, 0);
        expectAt(1, "resume1", 2, RUN, 0, 1);
        expectAt(2, "resume2", 3, RUN, 0, 1);
        expectAt(14, "resume9", 9, RUN, 0, -1);
        expectAt(16, "resTerm", 9, DONE, 1, -1);
        expectAt(17, "resHold", 9, DONE, 0, -1);
        tick(17);

        // STOP coincident with a terminal step: no tc_pulse.
        applyStimulus(OP_LOAD, 4'd2, 1'b0, 4'd0);
        applyStimulus(OP_START, 4'd0, 1'b0, 4'd0);
        expectAt(2, "preTerm", 2, RUN, 0, -1);
        tick(2);
        applyStimulus(OP_STOP, 4'd0, 1'b0, 4'd0);
        expectAt(0, "stopTerm", 2, PAUSE, 0, 0);
        expectAt(1, "stopTerm1", 2, PAUSE, 0, 1);

        // CLEAR coincident with a terminal step in periodic RUN.
        applyStimulus(OP_CLEAR, 4'd0, 1'b0, 4'd0);
        applyStimulus(OP_START, 4'd0, 1'b1, 4'd0);
        expectAt(1, "clrPre1", 1, RUN, 0, -1);
        expectAt(2, "clrPre2", 2, RUN, 0, -1);
        tick(2);
        applyStimulus(OP_CLEAR, 4'd0, 1'b0, 4'd0);
        expectAt(0, "clrStep", 0, RUN, 0, 0);
        expectAt(1, "clrStep1", 1, RUN, 0, 1);
        expectAt(2, "clrStep2", 2, RUN, 0, -1);
        expectAt(3, "clrWrap", 0, RUN, 1, -1);
        expectAt(4, "clrWrap1", 1, RUN, 0, -1);
        tick(4);

        // Limit lowered below count while running: wrap then terminate.
        applyStimulus(OP_STOP, 4'd0, 1'b0, 4'd0);
        applyStimulus(OP_CLEAR, 4'd0, 1'b0, 4'd0);
        applyStimulus(OP_LOAD, 4'd15, 1'b0, 4'd0);
        applyStimulus(OP_START, 4'd0, 1'b1, 4'd0);
        expectAt(8, "low8", 8, RUN, 0, -1);
        tick(8);
        applyStimulus(OP_LOAD, 4'd4, 1'b0, 4'd0);
        expectAt(0, "lowLoad", 8, RUN, 0, 0);
        expectAt(1, "low9", 9, RUN, 0, 1);
        expectAt(7, "low15", 15, RUN, 0, -1);
        expectAt(8, "lowWrap", 0, RUN, 0, -1);
        expectAt(12, "low4", 4, RUN, 0, -1);
        expectAt(13, "lowTerm", 0, RUN, 1, -1);
        expectAt(14, "lowNext", 1, RUN, 0, -1);
        tick(14);

        // Back-to-back commands: second one waits a cycle for cmd_ready.
        cmdOp    = OP_LOAD;
        cmdData  = 4'd7;
        cmdValid = 1'b1;
        tick(1);
        expectAt(0, "b2bLoad", 1, RUN, 0, 0);
        cmdOp = OP_STOP;
        tick(1);
        expectAt(0, "b2bWait", 2, RUN, 0, 1);
        tick(1);
        cmdValid = 1'b0;
        expectAt(0, "b2bStop", 2, PAUSE, 0, 0);
        expectAt(1, "b2bIdle", 2, PAUSE, 0, 1);
        tick(1);

        // Limit 0, periodic, prescale 0: tc every cycle, count stuck at 0.
        applyStimulus(OP_LOAD, 4'd0, 1'b0, 4'd0);
        applyStimulus(OP_CLEAR, 4'd0, 1'b0, 4'd0);
        applyStimulus(OP_START, 4'd0, 1'b1, 4'd0);
        expectAt(0, "lim0a", 0, RUN, 0, 0);
        for (int k = 1; k <= 4; k++) expectAt(k, "lim0tc", 0, RUN, 1, -1);
        tick(4);

        // Asynchronous reset while tc_pulse is high.
        #5;
        expectAt(0, "rstTc", 0, IDLE, 0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end
        printSummary();
        $finish;
    end

endmodule
